// File: rtl/payload_list_buffer.sv
// payload_list_buffer: linked-list beat store with a hardware-built free list, TTL-counted reads and packet admission.
// Writes pop the free list one beat per cycle; reads stream a chain and age or recycle each accepted beat.
module payload_list_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH = 4096,
    parameter int TTL_W = 3,
    parameter int MAX_BEATS = 32,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BW = $clog2(DATA_W / 8) + 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    output logic [ADDR_W:0]   free_count,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BW-1:0]     wr_bytes,
    input  logic [TTL_W-1:0]  wr_ttl,
    input  logic              wr_last,
    output logic              wr_done,
    output logic [ADDR_W-1:0] wr_head,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_head,
    output logic              rd_start_ack,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [BW-1:0]     rd_bytes,
    output logic              rd_last
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
    typedef enum logic [2:0] {INIT, IDLE, WRITE, RFETCH, RLOAD, READ} state_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TTL_W-1:0]  ttl;
        logic [BW-1:0]     bytes;
        logic              last;
        logic [ADDR_W-1:0] nxt;
    } entry_t;
    entry_t mem [DEPTH];
    entry_t q, out_e, wdata;
    state_t state;
    logic [ADDR_W-1:0] raddr, waddr, free_head, free_nxt, cur, nxt_addr, init_idx;
    logic we, wr_acc, rd_acc, rd_free;
    assign wr_ready = (state == WRITE) || (state == IDLE && int'(free_count) >= MAX_BEATS);
    assign wr_acc = wr_valid && wr_ready;
    assign rd_acc = state == READ && rd_valid && rd_ready;
    assign rd_free = rd_acc && out_e.ttl == '0;
    assign rd_data = out_e.data;
    assign rd_bytes = out_e.bytes;
    assign rd_last = out_e.last;
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        q <= mem[raddr];
    end
    // q is kept equal to mem[free_nxt] outside reads so a pop can follow the list every cycle
    always_comb begin
        we = 1'b0;
        waddr = free_head;
        wdata = {wr_data, wr_ttl, wr_bytes, wr_last, free_nxt};
        raddr = free_nxt;
        if (state == INIT) begin
            we = 1'b1;
            waddr = init_idx;
            wdata = '0;
            wdata.nxt = init_idx + 1'b1;
        end else if (wr_acc) begin
            we = 1'b1;
            raddr = q.nxt;
        end else if (state == RFETCH) begin
            raddr = nxt_addr;
        end else if (state == RLOAD) begin
            raddr = q.nxt;
        end else if (state == READ) begin
            raddr = nxt_addr;
            if (rd_acc) begin
                we = 1'b1;
                waddr = cur;
                wdata = out_e;
                wdata.ttl = rd_free ? out_e.ttl : out_e.ttl - 1'b1;
                wdata.nxt = rd_free ? free_head : out_e.nxt;
                raddr = out_e.last ? (rd_free ? free_head : free_nxt) : q.nxt;
            end
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
            init_idx <= '0;
            init_done <= 1'b0;
            free_count <= '0;
            free_head <= '0;
            free_nxt <= ADDR_W'(1);
            wr_done <= 1'b0;
            wr_head <= '0;
            rd_start_ack <= 1'b0;
            rd_valid <= 1'b0;
            out_e <= '0;
            cur <= '0;
            nxt_addr <= '0;
        end else begin
            wr_done <= 1'b0;
            rd_start_ack <= 1'b0;
            unique case (state)
                INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        init_done <= 1'b1;
                        free_count <= FULL;
                    end
                end
                IDLE, WRITE: begin
                    if (wr_acc) begin
                        free_head <= free_nxt;
                        free_nxt <= q.nxt;
                        if (free_count != '0) free_count <= free_count - 1'b1;
                        if (state == IDLE) wr_head <= free_head;
                        wr_done <= wr_last;
                        state <= wr_last ? IDLE : WRITE;
                    end else if (state == IDLE && rd_start) begin
                        rd_start_ack <= 1'b1;
                        nxt_addr <= rd_head;
                        state <= RFETCH;
                    end
                end
                RFETCH: state <= RLOAD;
                RLOAD: begin
                    out_e <= q;
                    cur <= nxt_addr;
                    nxt_addr <= q.nxt;
                    rd_valid <= 1'b1;
                    state <= READ;
                end
                READ: begin
                    if (rd_acc) begin
                        if (rd_free) begin
                            free_head <= cur;
                            free_nxt <= free_head;
                            if (free_count != FULL) free_count <= free_count + 1'b1;
                        end
                        if (out_e.last) begin
                            rd_valid <= 1'b0;
                            state <= IDLE;
                        end else begin
                            out_e <= q;
                            cur <= nxt_addr;
                            nxt_addr <= q.nxt;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_payload_list_buffer.sv
// tb_payload_list_buffer: directed and randomized packet traffic against a packet-level reference model.
module tb_payload_list_buffer;
    localparam int DW = 64, DEPTH = 16, TW = 3, MAXB = 4, AW = 4, BW = 4;
    logic clock = 1'b0, reset = 1'b1;
    always #5 clock = ~clock;
    logic wr_valid = 0, wr_last = 0, rd_start = 0, rd_ready = 0;
    logic [DW-1:0] wr_data = '0;
    logic [BW-1:0] wr_bytes = '0;
    logic [TW-1:0] wr_ttl = '0;
    logic [AW-1:0] rd_head = '0;
    logic init_done, wr_ready, wr_done, rd_start_ack, rd_valid, rd_last;
    logic [AW:0] free_count;
    logic [AW-1:0] wr_head;
    logic [DW-1:0] rd_data;
    logic [BW-1:0] rd_bytes;
    logic b_init_done, b_wr_ready, b_wr_done, b_rd_start_ack, b_rd_valid, b_rd_last;
    logic [AW:0] b_free_count;
    logic [AW-1:0] b_wr_head;
    logic [DW-1:0] b_rd_data;
    logic [BW-1:0] b_rd_bytes;
    payload_list_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .TTL_W(TW), .MAX_BEATS(MAXB)) dut (
        .clock(clock), .reset(reset), .init_done(init_done), .free_count(free_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_bytes(wr_bytes),
        .wr_ttl(wr_ttl), .wr_last(wr_last), .wr_done(wr_done), .wr_head(wr_head),
        .rd_start(rd_start), .rd_head(rd_head), .rd_start_ack(rd_start_ack), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_bytes(rd_bytes), .rd_last(rd_last));
    payload_list_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .TTL_W(TW), .MAX_BEATS(32)) big (
        .clock(clock), .reset(reset), .init_done(b_init_done), .free_count(b_free_count),
        .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_data(wr_data), .wr_bytes(wr_bytes),
        .wr_ttl(wr_ttl), .wr_last(wr_last), .wr_done(b_wr_done), .wr_head(b_wr_head),
        .rd_start(rd_start), .rd_head(rd_head), .rd_start_ack(b_rd_start_ack), .rd_valid(b_rd_valid),
        .rd_ready(rd_ready), .rd_data(b_rd_data), .rd_bytes(b_rd_bytes), .rd_last(b_rd_last));
    int checks = 0, errors = 0;
    logic [DW-1:0] m_data [DEPTH][MAXB];
    logic [BW-1:0] m_bytes [DEPTH][MAXB];
    int m_len [DEPTH];
    int m_ttl [DEPTH];
    int m_free;
    int live[$];
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    task automatic do_reset;
        reset = 1;
        wr_valid = 0; wr_last = 0; rd_start = 0; rd_ready = 0;
        tick; tick;
        chk("rst_init_done", init_done, 0);
        chk("rst_free_count", free_count, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_wr_head", wr_head, 0);
        chk("rst_rd_ack", rd_start_ack, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_bytes", rd_bytes, 0);
        chk("rst_rd_last", rd_last, 0);
        reset = 0;
        repeat (DEPTH - 1) tick;
        chk("init_early", init_done, 0);
        tick;
        chk("init_done", init_done, 1);
        chk("init_free", free_count, DEPTH);
        chk("init_wr_ready", wr_ready, 1);
        chk("big_init_done", b_init_done, 1);
        chk("big_free", b_free_count, DEPTH);
        chk("big_wr_ready", b_wr_ready, 0);
        m_free = DEPTH;
        live.delete();
    endtask
    task automatic write_pkt(input int n, input int ttl, input bit fixed, input logic [DW-1:0] base,
                             input bit gaps, input bit with_rd, output logic [AW-1:0] head);
        logic [DW-1:0] pd [MAXB];
        logic [BW-1:0] pb [MAXB];
        int g = 0;
        while (!wr_ready && g < 50) begin tick; g++; end
        chk("wr_ready_wait", wr_ready, 1);
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0 && $urandom_range(0, 2) == 0) begin wr_valid = 0; tick; end
            pd[k] = fixed ? base + DW'(k) : {$urandom, $urandom};
            pb[k] = BW'($urandom_range(1, 8));
            wr_valid = 1; wr_data = pd[k]; wr_bytes = pb[k]; wr_ttl = TW'(ttl); wr_last = (k == n - 1);
            rd_start = with_rd && k == 0; rd_head = '0;
            if (k > 0) chk("wr_ready_pkt", wr_ready, 1);
            tick;
            if (with_rd && k == 0) begin
                rd_start = 0;
                chk("rd_ack_blocked", rd_start_ack, 0);
            end
        end
        wr_valid = 0; wr_last = 0;
        chk("wr_done", wr_done, 1);
        head = wr_head;
        m_len[head] = n;
        m_ttl[head] = ttl;
        for (int k = 0; k < n; k++) begin m_data[head][k] = pd[k]; m_bytes[head][k] = pb[k]; end
        m_free -= n;
        live.push_back(int'(head));
        chk("free_after_wr", free_count, m_free);
        tick;
        chk("wr_done_pulse", wr_done, 0);
    endtask
    task automatic read_pkt(input logic [AW-1:0] head, input int mode);
        logic [3:0] pat = 4'b1001;
        int g = 0, k = 0, n = m_len[head];
        bit acked = 0, rdy;
        rd_head = head; rd_ready = 0;
        while (!acked && g < 20) begin
            rd_start = 1; tick; rd_start = 0;
            acked = rd_start_ack; g++;
        end
        chk("rd_ack", acked, 1);
        tick;
        chk("rd_lat_early", rd_valid, 0);
        tick;
        g = 0;
        while (k < n && g < 300) begin
            rdy = mode == 0 ? 1'b1 : mode == 1 ? pat[g % 4] : ($urandom_range(0, 3) != 0);
            rd_ready = rdy;
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, m_data[head][k]);
            chk("rd_bytes", rd_bytes, m_bytes[head][k]);
            chk("rd_last", rd_last, k == n - 1);
            if (rdy) k++;
            tick; g++;
        end
        rd_ready = 0;
        chk("rd_beats", k, n);
        chk("rd_valid_end", rd_valid, 0);
        if (m_ttl[head] == 0) begin
            m_free += n;
            foreach (live[i]) if (live[i] == int'(head)) begin live.delete(i); break; end
        end else m_ttl[head]--;
        chk("free_after_rd", free_count, m_free);
        chk("wr_ready_after_rd", wr_ready, m_free >= MAXB);
    endtask
    initial begin
        logic [AW-1:0] h, p1, p2, p3, p4;
        int guard;
        do_reset;
        write_pkt(3, 1, 1, 64'hA, 0, 0, h);
        chk("first_head", h, 0);
        chk("free_13", free_count, DEPTH - 3);
        read_pkt(h, 0);
        chk("free_after_read1", free_count, DEPTH - 3);
        read_pkt(h, 0);
        chk("free_after_read2", free_count, DEPTH);
        write_pkt(4, 0, 0, 0, 0, 0, h);
        read_pkt(h, 1);
        write_pkt(4, 0, 0, 0, 1, 0, p1);
        write_pkt(4, 0, 0, 0, 1, 0, p2);
        write_pkt(4, 0, 0, 0, 1, 0, p3);
        write_pkt(1, 0, 0, 0, 0, 0, p4);
        chk("free_maxb_m1", free_count, MAXB - 1);
        chk("wr_ready_low", wr_ready, 0);
        read_pkt(p4, 0);
        chk("wr_ready_reopen", wr_ready, 1);
        read_pkt(p2, 2);
        read_pkt(p1, 1);
        read_pkt(p3, 0);
        write_pkt(2, 0, 0, 0, 0, 1, h);
        read_pkt(h, 0);
        chk("free_before_rand", free_count, DEPTH);
        repeat (60) begin
            if (m_free >= MAXB && (live.size() == 0 || $urandom_range(0, 1) == 1))
                write_pkt($urandom_range(1, MAXB), $urandom_range(0, 2), 0, 0, 1, $urandom_range(0, 1), h);
            else
                read_pkt(AW'(live[$urandom_range(0, live.size() - 1)]), 2);
        end
        guard = 0;
        while (live.size() > 0 && guard < 200) begin read_pkt(AW'(live[0]), 0); guard++; end
        chk("free_drained", free_count, DEPTH);
        write_pkt(4, 2, 0, 0, 0, 0, h);
        rd_head = h; rd_start = 1; tick; rd_start = 0;
        chk("mid_rd_ack", rd_start_ack, 1);
        tick; tick;
        chk("mid_rd_valid", rd_valid, 1);
        rd_ready = 1; tick; rd_ready = 0;
        #2 reset = 1;
        #1;
        chk("async_rd_valid", rd_valid, 0);
        chk("async_init_done", init_done, 0);
        chk("async_free", free_count, 0);
        chk("async_wr_ready", wr_ready, 0);
        chk("async_rd_data", rd_data, 0);
        do_reset;
        write_pkt(3, 0, 1, 64'h55, 0, 0, h);
        chk("post_rst_head", h, 0);
        read_pkt(h, 2);
        chk("post_rst_free", free_count, DEPTH);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
